// File: rtl/cam_dvp_tx.sv
// Camera-side DVP transmitter: streams t_colors pixels as RGB565 byte pairs on vsync/href/pclk/data.
// Optional colour-bar source is built only when CAM_DVP_TX_PATTERN_EN is defined (selected by test_mode).
module cam_dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        test_mode,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam int LINE = 2*H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LINE + 1);
  localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);
  localparam logic [HW-1:0] H_HREF = HW'(2*H_ACTIVE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;
  // Transient "frame over" token; resolved to VSYNC-chain or IDLE, never stored.
  localparam logic [2:0] S_WRAP   = 3'd5;

  function automatic logic [2:0] skip_empty(input logic [2:0] s);
    logic [2:0] r;
    r = s;
    if (r == S_VSYNC  && VSYNC_LINES == 0) r = S_VBACK;
    if (r == S_VBACK  && V_BACK == 0)      r = S_ACTIVE;
    if (r == S_VFRONT && V_FRONT == 0)     r = S_WRAP;
    return r;
  endfunction

  function automatic logic [15:0] last_line(input logic [2:0] s);
    logic [15:0] n;
    case (s)
      S_VSYNC:  n = 16'(VSYNC_LINES - 1);
      S_VBACK:  n = 16'(V_BACK - 1);
      S_ACTIVE: n = 16'(V_ACTIVE - 1);
      default:  n = 16'(V_FRONT - 1);
    endcase
    return n;
  endfunction

  logic [2:0]    state_q, state_d, succ;
  logic          phase_q, phase_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [15:0]   vcnt_q, vcnt_d;
  logic          frame_start_q, frame_start_d;
  logic          underflow_q, underflow_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          line_end;

  always_comb begin
    state_d       = state_q;
    phase_d       = 1'b0;
    hcnt_d        = '0;
    vcnt_d        = '0;
    frame_start_d = 1'b0;
    succ          = S_IDLE;
    line_end      = phase_q && (hcnt_q == H_LAST);
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d       = skip_empty(S_VSYNC);
        frame_start_d = 1'b1;
      end
    end else begin
      phase_d = ~phase_q;
      hcnt_d  = line_end ? '0 : hcnt_q + HW'(phase_q);
      vcnt_d  = vcnt_q;
      if (line_end) begin
        vcnt_d = vcnt_q + 16'd1;
        if (vcnt_q == last_line(state_q)) begin
          vcnt_d = '0;
          case (state_q)
            S_VSYNC:  succ = S_VBACK;
            S_VBACK:  succ = S_ACTIVE;
            S_ACTIVE: succ = S_VFRONT;
            default:  succ = S_WRAP;
          endcase
          state_d = skip_empty(succ);
          // enable only matters here and in IDLE, so a mid-frame drop finishes the frame
          if (state_d == S_WRAP) begin
            state_d       = enable ? skip_empty(S_VSYNC) : S_IDLE;
            frame_start_d = enable;
          end
        end
      end
    end
  end

  logic        href_w;
  logic        take;
  logic        pattern_on;
  logic        pix_ok;
  logic [23:0] src_pix;
  logic [7:0]  byte0_w, byte1_w, data_now;

`ifdef CAM_DVP_TX_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE/8 > 0) ? H_ACTIVE/8 : 1;
  logic        test_q, test_d;
  logic [23:0] bar_pix;

  always_comb begin
    int bar;
    bar = int'(hcnt_q[HW-1:1]) / BAR_W;
    case (bar)
      0:       bar_pix = 24'hFFFFFF;
      1:       bar_pix = 24'hFFFF00;
      2:       bar_pix = 24'h00FFFF;
      3:       bar_pix = 24'h00FF00;
      4:       bar_pix = 24'hFF00FF;
      5:       bar_pix = 24'hFF0000;
      6:       bar_pix = 24'h0000FF;
      default: bar_pix = 24'h000000;
    endcase
  end

  assign test_d     = frame_start_d ? test_mode : test_q;
  assign pattern_on = test_q;
  assign src_pix    = test_q ? bar_pix : pix_in;
  assign pix_ok     = test_q || pix_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) test_q <= 1'b0;
    else        test_q <= test_d;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pattern_on       = 1'b0;
  assign src_pix          = pix_in;
  assign pix_ok           = pix_valid;
`endif

  // RGB565 drops the low channel bits
  logic [7:0] unused_pix_bits;
  assign unused_pix_bits = {src_pix[18:16], src_pix[9:8], src_pix[2:0]};

  assign href_w  = (state_q == S_ACTIVE) && (hcnt_q < H_HREF);
  assign take    = href_w && !hcnt_q[0] && !phase_q;
  assign byte0_w = {src_pix[23:19], src_pix[15:13]};
  assign byte1_w = {src_pix[12:10], src_pix[7:3]};

  always_comb begin
    data_now = 8'h00;
    if (href_w) begin
      if (hcnt_q[0])   data_now = byte1_q;
      else if (pix_ok) data_now = byte0_w;
    end
    data_d      = phase_q ? data_q : data_now;
    byte1_d     = take ? (pix_ok ? byte1_w : 8'h00) : byte1_q;
    underflow_d = underflow_q | (take && !pix_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      data_q        <= 8'h00;
      byte1_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      data_q        <= data_d;
      byte1_q       <= byte1_d;
    end
  end

  // Phase 0 shows the slot byte as it is formed; phase 1 holds the registered copy across pclk rise.
  assign cam_data    = phase_q ? data_q : data_now;
  assign cam_pclk    = phase_q;
  assign cam_vsync   = (state_q == S_VSYNC);
  assign cam_href    = href_w;
  assign pix_ready   = take && pix_valid && !pattern_on;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule
